// File: rtl/lsu_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl_if
// Purpose  : Bundles the request, response and data-memory signals of the
//            load/store initiator.
//            slave  - seen from lsu_mem_ctrl (takes requests, drives memory)
//            master - seen from the requester / memory model side
// Signals  : request  : i_req_valid, o_req_ready, i_req_we, i_req_funct3,
//                       i_req_addr, i_req_wdata
//            response : o_rsp_valid, i_rsp_ready, o_rsp_rdata, o_rsp_err
//            memory   : o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wren,
//                       i_mem_rdata
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_mem_ctrl_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;

    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    logic [15:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        o_mem_wren;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
        output o_req_ready,
        output o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  i_rsp_ready,
        output o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wren,
        input  i_mem_rdata
    );

    modport master (
        output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
        input  o_req_ready,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output i_rsp_ready,
        input  o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wren,
        output i_mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Purpose  : RV32I load/store initiator between execute stage and a
//            byte-addressable data memory. One request per transaction:
//            IDLE (accept) -> ACCESS (drive memory one cycle) -> RESP (hold
//            response until consumed). Faulting accesses (illegal funct3,
//            out of range, misaligned) never touch memory.
// Ports    : i_clk    - clock, rising edge
//            i_reset  - asynchronous active-low reset
//            bus      - lsu_mem_ctrl_if.slave (request/response/memory)
// Params   : MEM_BYTES        - memory size in bytes
//            ALLOW_MISALIGNED - 1 lets halfword/word use any byte address
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter int unsigned MEM_BYTES        = 32768,
    parameter bit          ALLOW_MISALIGNED = 1'b0
) (
    input  logic           i_clk,
    input  logic           i_reset,
    lsu_mem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [32:0] c_mem_bytes = 33'(MEM_BYTES);

    state_t      r_state;
    state_t      w_state_next;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [15:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        w_accept;
    logic [2:0]  w_size;
    logic [32:0] w_last;
    logic        w_f3_illegal;
    logic        w_out_of_range;
    logic        w_misaligned;
    logic        w_req_err;
    logic [31:0] w_load_data;

    // ------------------------------------------------------------------
    // Request decode (evaluated on the live request, latched on accept)
    // ------------------------------------------------------------------
    always_comb begin
        case (bus.i_req_funct3[1:0])
            2'd0:    w_size = 3'd1;
            2'd1:    w_size = 3'd2;
            default: w_size = 3'd4;
        endcase

        if (bus.i_req_we) begin
            w_f3_illegal = (bus.i_req_funct3 > 3'd2);
        end else begin
            w_f3_illegal = (bus.i_req_funct3 == 3'd3) ||
                           (bus.i_req_funct3 == 3'd6) ||
                           (bus.i_req_funct3 == 3'd7);
        end

        // 33-bit sum so addresses near 2^32 cannot wrap into range.
        w_last         = {1'b0, bus.i_req_addr} + {30'd0, w_size} - 33'd1;
        w_out_of_range = (w_last >= c_mem_bytes);

        w_misaligned = 1'b0;
        if (!ALLOW_MISALIGNED) begin
            w_misaligned = ((bus.i_req_funct3[1:0] == 2'd1) && bus.i_req_addr[0]) ||
                           ((bus.i_req_funct3[1:0] == 2'd2) && (bus.i_req_addr[1:0] != 2'd0));
        end

        w_req_err = w_f3_illegal || w_out_of_range || w_misaligned;
    end

    // ------------------------------------------------------------------
    // Load data extension from the combinational memory read
    // ------------------------------------------------------------------
    always_comb begin
        case (r_funct3)
            3'd0:    w_load_data = {{24{bus.i_mem_rdata[7]}},  bus.i_mem_rdata[7:0]};
            3'd1:    w_load_data = {{16{bus.i_mem_rdata[15]}}, bus.i_mem_rdata[15:0]};
            3'd2:    w_load_data = bus.i_mem_rdata;
            3'd4:    w_load_data = {24'd0, bus.i_mem_rdata[7:0]};
            3'd5:    w_load_data = {16'd0, bus.i_mem_rdata[15:0]};
            default: w_load_data = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs. Mask/wren decode the ACCESS state so an
    // asynchronous reset removes a pending write immediately.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_accept        = 1'b0;
        bus.o_req_ready = 1'b0;
        bus.o_mem_mask  = 4'b0000;
        bus.o_mem_wren  = 1'b0;

        case (r_state)
            S_IDLE: begin
                bus.o_req_ready = 1'b1;
                if (bus.i_req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!r_err) begin
                    case (r_funct3[1:0])
                        2'd0:    bus.o_mem_mask = 4'b0001;
                        2'd1:    bus.o_mem_mask = 4'b0011;
                        default: bus.o_mem_mask = 4'b1111;
                    endcase
                end
                bus.o_mem_wren = r_we & ~r_err;
                w_state_next   = S_RESP;
            end
            S_RESP: begin
                if (bus.i_rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= 16'd0;
            r_wdata     <= 32'd0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we     <= bus.i_req_we;
                r_funct3 <= bus.i_req_funct3;
                r_addr   <= bus.i_req_addr[15:0];
                r_wdata  <= bus.i_req_wdata;
                r_err    <= w_req_err;
            end
            if (r_state == S_ACCESS) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= r_err;
                r_rsp_rdata <= (!r_we && !r_err) ? w_load_data : 32'd0;
            end
            if ((r_state == S_RESP) && bus.i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // Memory address/data come straight from the latch, so they hold their
    // last value outside ACCESS.
    assign bus.o_mem_addr  = r_addr;
    assign bus.o_mem_wdata = r_wdata;
    assign bus.o_rsp_valid = r_rsp_valid;
    assign bus.o_rsp_rdata = r_rsp_rdata;
    assign bus.o_rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
